// File: rtl/bcd_updown_counter_if.sv
// Bus bundle for bcd_updown_counter.
//   Push       : raw active-low buttons, [1] = up, [0] = down, 2'b11 = idle
//   Load_i     : synchronous load strobe, active-high
//   Load_val_i : BCD value to load, digit 0 in [3:0]
//   Cnt_o_LED  : current count in BCD, digit 0 in [3:0]
//   Cnt_o_FND  : 7-segment codes {g..a} per digit, digit 0 in [6:0]
//   Limit_o    : one-cycle pulse on wrap or on a step blocked by saturation
// master = stimulus/consumer side, slave = counter side.
interface bcd_updown_counter_if #(
  parameter int unsigned DIGITS = 3
);
  logic [1:0]          Push;
  logic                Load_i;
  logic [4*DIGITS-1:0] Load_val_i;
  logic [4*DIGITS-1:0] Cnt_o_LED;
  logic [7*DIGITS-1:0] Cnt_o_FND;
  logic                Limit_o;

  modport master (
    output Push, Load_i, Load_val_i,
    input  Cnt_o_LED, Cnt_o_FND, Limit_o
  );

  modport slave (
    input  Push, Load_i, Load_val_i,
    output Cnt_o_LED, Cnt_o_FND, Limit_o
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter driven by two active-low push buttons.
// Each button is synchronised, debounced and optionally auto-repeated; the count
// supports parallel load (digits clamped to 9) and wraps or saturates at its limits.
// Ports:
//   Clk : system clock, rising edge
//   Rst : asynchronous active-low reset
//   bus : bcd_updown_counter_if.slave (Push, Load_i, Load_val_i, Cnt_o_LED,
//         Cnt_o_FND, Limit_o)
module bcd_updown_counter #(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned DEBOUNCE_CYC   = 4,
  parameter int unsigned REPEAT_DLY     = 0,
  parameter int unsigned REPEAT_PER     = 8,
  parameter bit          WRAP           = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic                Clk,
  input logic                Rst,
  bcd_updown_counter_if.slave bus
);

  localparam int unsigned CntW   = 4 * DIGITS;
  localparam int unsigned FndW   = 7 * DIGITS;
  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned RepMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned RtW    = $clog2(RepMax + 1);

  localparam logic [DbW-1:0] DbLast  = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [RtW-1:0] DlyLast = RtW'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
  localparam logic [RtW-1:0] PerLast = RtW'(REPEAT_PER - 1);

  localparam logic [6:0]      SegZero = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;
  localparam logic [FndW-1:0] FndRst  = {DIGITS{SegZero}};

  typedef enum logic [1:0] {StIdle, StHold, StRepeat} rep_st_e;

  // Input path, one lane per button: [1] = up, [0] = down.
  logic [1:0]     sync1_q, sync2_q, db_q, db_d, db_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [DbW-1:0] db_cnt_d [2];
  rep_st_e        rep_st_q [2];
  rep_st_e        rep_st_d [2];
  logic [RtW-1:0] tmr_q [2];
  logic [RtW-1:0] tmr_d [2];
  logic [1:0]     press, rep_req, req;
  logic           both_low;
  logic           step_up_d, step_up_q, step_dn_d, step_dn_q;

  logic [CntW-1:0] cnt_q, cnt_d, inc_val, dec_val;
  logic            inc_carry, dec_borrow;
  logic            limit_q, limit_d;
  logic [FndW-1:0] fnd_q, fnd_d;

  function automatic logic [6:0] seg_encode(logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive differing cycles.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      db_d[b]     = db_q[b];
      db_cnt_d[b] = '0;
      if (sync2_q[b] != db_q[b]) begin
        if (db_cnt_q[b] == DbLast) begin
          db_d[b] = sync2_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  assign press    = db_prev_q & ~db_q;
  assign both_low = ~|db_q;

  // Per-button auto-repeat; the FSMs stay idle when REPEAT_DLY is 0.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      rep_st_d[b] = rep_st_q[b];
      tmr_d[b]    = tmr_q[b];
      rep_req[b]  = 1'b0;
      if (REPEAT_DLY != 0) begin
        case (rep_st_q[b])
          StIdle: begin
            if (press[b]) begin
              rep_st_d[b] = StHold;
              tmr_d[b]    = '0;
            end
          end
          StHold, StRepeat: begin
            if (db_q[b]) begin
              rep_st_d[b] = StIdle;
              tmr_d[b]    = '0;
            end else if (both_low) begin
              tmr_d[b] = '0;
            end else if (tmr_q[b] == ((rep_st_q[b] == StHold) ? DlyLast : PerLast)) begin
              rep_req[b]  = 1'b1;
              rep_st_d[b] = StRepeat;
              tmr_d[b]    = '0;
            end else begin
              tmr_d[b] = tmr_q[b] + 1'b1;
            end
          end
          default: begin
            rep_st_d[b] = StIdle;
            tmr_d[b]    = '0;
          end
        endcase
      end
    end
  end

  // A step needs exactly one requesting button and never fires while both are held.
  assign req       = press | rep_req;
  assign step_up_d = req[1] & ~req[0] & ~both_low;
  assign step_dn_d = req[0] & ~req[1] & ~both_low;

  // Ripple BCD increment/decrement; a carry/borrow out of the top digit marks the limit.
  always_comb begin
    inc_val    = cnt_q;
    dec_val    = cnt_q;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (inc_carry) begin
        if (cnt_q[4*d +: 4] == 4'd9) begin
          inc_val[4*d +: 4] = 4'd0;
        end else begin
          inc_val[4*d +: 4] = cnt_q[4*d +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (cnt_q[4*d +: 4] == 4'd0) begin
          dec_val[4*d +: 4] = 4'd9;
        end else begin
          dec_val[4*d +: 4] = cnt_q[4*d +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
    end
  end

  // Load wins over a same-cycle step, which is dropped.
  always_comb begin
    cnt_d   = cnt_q;
    limit_d = 1'b0;
    if (bus.Load_i) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        cnt_d[4*d +: 4] = (bus.Load_val_i[4*d +: 4] > 4'd9) ? 4'd9 : bus.Load_val_i[4*d +: 4];
      end
    end else if (step_up_q) begin
      limit_d = inc_carry;
      cnt_d   = (inc_carry && !WRAP) ? cnt_q : inc_val;
    end else if (step_dn_q) begin
      limit_d = dec_borrow;
      cnt_d   = (dec_borrow && !WRAP) ? cnt_q : dec_val;
    end
  end

  always_comb begin
    fnd_d = '0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      fnd_d[7*d +: 7] = seg_encode(cnt_q[4*d +: 4]);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      db_q      <= 2'b11;
      db_prev_q <= 2'b11;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b] <= '0;
        rep_st_q[b] <= StIdle;
        tmr_q[b]    <= '0;
      end
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      cnt_q     <= '0;
      limit_q   <= 1'b0;
      fnd_q     <= FndRst;
    end else begin
      sync1_q   <= bus.Push;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b] <= db_cnt_d[b];
        rep_st_q[b] <= rep_st_d[b];
        tmr_q[b]    <= tmr_d[b];
      end
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      fnd_q     <= fnd_d;
    end
  end

  assign bus.Cnt_o_LED = cnt_q;
  assign bus.Cnt_o_FND = fnd_q;
  assign bus.Limit_o   = limit_q;

endmodule
